// File: rtl/rf_pkg.sv
// Shared widths and helpers for the multi-port register file.
// The optional scoreboard is enabled by defining REGISTER_FILE_MP_SCOREBOARD_EN.
package rf_pkg;
  localparam int RF_N              = 32;
  localparam int RF_L              = 5;
  localparam int RF_MAX_READ_PORTS = 4;

  // Low bit of lane p in a flattened bus whose lanes are w bits wide.
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction
endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: one write port, flattened read ports and,
// when REGISTER_FILE_MP_SCOREBOARD_EN is defined, the reserve/busy signals.
// Handshake: there is no valid/ready pair. wr_ena, rd_ena[p] and rsv_ena are
// qualifiers sampled on the rising clock edge. rd_data and rd_busy are
// registered and become valid exactly one cycle after the edge that sampled
// rd_ena[p]=1. They hold their value while rd_ena[p]=0.
interface register_file_mp_if
  import rf_pkg::*;
#(
  parameter int N          = RF_N,
  parameter int L          = RF_L,
  parameter int READ_PORTS = 2
);
  logic                    wr_ena;
  logic [L-1:0]            wr_addr;
  logic [N-1:0]            wr_data;
  logic [READ_PORTS-1:0]   rd_ena;
  logic [READ_PORTS*L-1:0] rd_addr;
  logic [READ_PORTS*N-1:0] rd_data;
`ifdef REGISTER_FILE_MP_SCOREBOARD_EN
  logic                    rsv_ena;
  logic [L-1:0]            rsv_addr;
  logic [READ_PORTS-1:0]   rd_busy;
`endif

  modport master (
    output wr_ena, wr_addr, wr_data, rd_ena, rd_addr,
`ifdef REGISTER_FILE_MP_SCOREBOARD_EN
    output rsv_ena, rsv_addr,
    input  rd_busy,
`endif
    input  rd_data
  );

  modport slave (
    input  wr_ena, wr_addr, wr_data, rd_ena, rd_addr,
`ifdef REGISTER_FILE_MP_SCOREBOARD_EN
    input  rsv_ena, rsv_addr,
    output rd_busy,
`endif
    output rd_data
  );
endinterface

// File: rtl/rf_read_port.sv
// One registered read port: address mux, write bypass, zero-register masking.
// With REGISTER_FILE_MP_SCOREBOARD_EN defined, it also registers the busy flag.
module rf_read_port #(
  parameter int N        = 32,
  parameter int L        = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_ena,
  input  logic [L-1:0] rd_addr,
  input  logic         wr_ena,
  input  logic [L-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [N-1:0] regs [2**L],
`ifdef REGISTER_FILE_MP_SCOREBOARD_EN
  input  logic [2**L-1:0] pending_nxt,
  output logic         rd_busy,
`endif
  output logic [N-1:0] rd_data
);
  logic         is_zero;
  logic [N-1:0] rd_value;

  // Select the new write data on an address match; force zero for register 0.
  always_comb begin
    is_zero  = (ZERO_REG != 0) && (rd_addr == '0);
    rd_value = regs[rd_addr];
    if (wr_ena && (wr_addr == rd_addr)) rd_value = wr_data;
    if (is_zero) rd_value = '0;
  end

  // Output register. It loads only on an enabled read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_ena) rd_data <= rd_value;
  end

`ifdef REGISTER_FILE_MP_SCOREBOARD_EN
  // Busy flag mirrors the pending state this edge produces, including any same-cycle set or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_busy <= 1'b0;
    else if (rd_ena) rd_busy <= pending_nxt[rd_addr] && !is_zero;
  end
`endif
endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with flop storage, registered read
// ports and write-to-read bypass. Defining REGISTER_FILE_MP_SCOREBOARD_EN adds
// a pending-result scoreboard with per-port busy flags.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int N          = RF_N,
  parameter int L          = RF_L,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);
  localparam int DEPTH = 2**L;

  logic [N-1:0] regs [DEPTH];
  logic         wr_drop;

  // Writes to register 0 are dropped when it is hardwired to zero.
  always_comb begin
    wr_drop = (ZERO_REG != 0) && (bus.wr_addr == '0);
  end

  // Storage update. Reset clears every register and discards an in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (bus.wr_ena && !wr_drop) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef REGISTER_FILE_MP_SCOREBOARD_EN
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;

  // A write retires the outstanding producer. A reservation after it wins on the same address.
  always_comb begin
    pending_nxt = pending;
    if (bus.wr_ena) pending_nxt[bus.wr_addr] = 1'b0;
    if (bus.rsv_ena && !((ZERO_REG != 0) && (bus.rsv_addr == '0)))
      pending_nxt[bus.rsv_addr] = 1'b1;
  end

  // Pending-bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else pending <= pending_nxt;
  end
`endif

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    rf_read_port #(
      .N        (N),
      .L        (L),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk         (clk),
      .rst         (rst),
      .rd_ena      (bus.rd_ena[p]),
      .rd_addr     (bus.rd_addr[slice_lo(p, L) +: L]),
      .wr_ena      (bus.wr_ena),
      .wr_addr     (bus.wr_addr),
      .wr_data     (bus.wr_data),
      .regs        (regs),
`ifdef REGISTER_FILE_MP_SCOREBOARD_EN
      .pending_nxt (pending_nxt),
      .rd_busy     (bus.rd_busy[p]),
`endif
      .rd_data     (bus.rd_data[slice_lo(p, N) +: N])
    );
  end
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file, successor to the fixed 32x32 two-read-port register file in the RISC-V core. Provides 2^L registers of N bits, READ_PORTS independent read ports with registered (1-cycle) outputs, and one write port with write-to-read bypass. An optional scoreboard tracks registers awaiting a result. Sits between decode (read addresses) and writeback (write port) in the core datapath.

## Interface
- N, 32, register width in bits
- L, 5, address width; depth = 2^L registers
- READ_PORTS, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes/reservations
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- wr_ena  in  1  write enable
- wr_addr  in  L  write address
- wr_data  in  N  write data
- rd_ena  in  READ_PORTS  per-port read enable
- rd_addr  in  READ_PORTS*L  port p address at bits [p*L +: L]
- rd_data  out  READ_PORTS*N  port p data at bits [p*N +: N], registered
- rsv_ena  in  1  reserve request (REGISTER_FILE_MP_SCOREBOARD_EN only)
- rsv_addr  in  L  register to mark pending (REGISTER_FILE_MP_SCOREBOARD_EN only)
- rd_busy  out  READ_PORTS  per-port pending flag, registered with rd_data (REGISTER_FILE_MP_SCOREBOARD_EN only)

## Operation
- Storage: 2^L flop registers, no inferred RAM; all cleared to 0 by rst.
- Write: on posedge with wr_ena=1, reg[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, write dropped.
- Read: on posedge with rd_ena[p]=1, rd_data[p] <= value of reg[rd_addr[p]]; rd_ena[p]=0 holds previous rd_data[p].
- Bypass: if wr_ena=1 and wr_addr=rd_addr[p] in the same cycle, rd_data[p] receives wr_data (new value), not the stale contents.
- Zero: with ZERO_REG=1, reads of address 0 return 0 regardless of bypass.
- Ports are independent; any number may read the same address, including the write address, in one cycle.
- Scoreboard (when enabled): pending[2^L] bits, cleared by rst.
  - rsv_ena=1: pending[rsv_addr] set on posedge.
  - wr_ena=1: pending[wr_addr] cleared on posedge.
  - Same address reserved and written in one cycle: set wins (new producer outstanding).
  - rd_busy[p] <= next-state pending of rd_addr[p] (includes same-cycle clear/set), updated only when rd_ena[p]=1.
  - ZERO_REG=1: reservations of address 0 ignored; rd_busy for address 0 always 0.

## Timing
- Write latency: 1 cycle; value visible to reads sampled on the same edge via bypass.
- Read latency: exactly 1 cycle from rd_addr/rd_ena sampled at edge k to rd_data valid after edge k.
- rst asserted: all registers, rd_data, rd_busy, pending -> 0 immediately, independent of clk; reset mid-write discards the write.
- First edge after rst deasserts operates normally.
- No combinational path from any input to any output.

## Configuration
- REGISTER_FILE_MP_SCOREBOARD_EN defined: rsv_ena, rsv_addr, rd_busy ports and pending state present, behaviour as above.
- Undefined: those ports and all pending logic are absent; read/write behaviour identical.

## Structure
- Package rf_pkg: default widths RF_N=32, RF_L=5, RF_MAX_READ_PORTS=4, and a slice helper function for flattened port buses.
- Sub-module rf_read_port: one address mux, bypass compare, zero-register masking, output register (and busy register when scoreboard enabled); instantiated READ_PORTS times via generate.

## Test plan
- Reset: write 0xDEADBEEF to reg 5, assert rst mid-cycle -> rd_data, rd_busy 0 at once; subsequent read of reg 5 returns 0.
- Basic: write 0x12345678 to reg 7, next cycle read reg 7 on port 0 and port 1 -> both 0x12345678 one cycle later.
- Bypass: same cycle wr_addr=9, wr_data=0xA5A5A5A5, rd_addr[0]=9 -> rd_data[0]=0xA5A5A5A5 after that edge.
- Zero reg: write 0xFFFFFFFF to reg 0, read reg 0 both ports (with and without same-cycle bypass) -> 0.
- Hold: rd_ena[1]=0 while rd_addr[1] changes -> rd_data[1] unchanged; READ_PORTS=3, N=16, L=4 instance passes the basic test.
- Scoreboard: reserve reg 3 -> read gives rd_busy=1; write reg 3 with read in same cycle -> rd_busy=0, data bypassed; reserve+write reg 3 together -> rd_busy=1.
